// File: rtl/joypad_poller_pkg.sv
// joypad_poller_pkg
//   Shared definitions for the joypad poller: CPU register offsets,
//   bridge readback select codes and the poll FSM state encoding.
//   Optional build macro used by the top: JOYPAD_POLLER_DEBOUNCE_EN.
package joypad_poller_pkg;

    // CPU-visible register offsets
    localparam logic [2:0] JP_REG_STATUS   = 3'd0;
    localparam logic [2:0] JP_REG_BUTTONS  = 3'd1;
    localparam logic [2:0] JP_REG_PRESSED  = 3'd2;
    localparam logic [2:0] JP_REG_RELEASED = 3'd3;
    localparam logic [2:0] JP_REG_IRQ_MASK = 3'd4;
    localparam logic [2:0] JP_REG_CTRL     = 3'd5;

    // Bridge readback window selects
    localparam logic [1:0] BR_ADDR_READY  = 2'b00;
    localparam logic [1:0] BR_ADDR_VALID  = 2'b01;
    localparam logic [1:0] BR_ADDR_JOYPAD = 2'b10;

    // Poll FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_VALID  = 3'd4,
        ST_FETCH  = 3'd5,
        ST_UPDATE = 3'd6
    } jp_state_t;

endpackage

// File: rtl/joypad_poller_timer.sv
// poll_timer
//   Free-running wrap counter that produces the automatic poll tick.
//   Ports:
//     clk  in  - clock
//     rst  in  - asynchronous active-high reset (counter -> 0)
//     tick out - high for the one cycle the counter sits at PERIOD-1
module poll_timer #(
    parameter int unsigned PERIOD = 833_333
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_cnt <= '0;
        else if (tick) r_cnt <= '0;
        else           r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/joypad_poller.sv
// joypad_poller
//   CPU-side polling front end for the NES-over-I2C bridge. Periodically
//   (or on CPU trigger) starts the bridge, reads back the joypad byte,
//   keeps active-high button state, sticky press/release masks and a
//   maskable level interrupt. Byte-wide register file on the peripheral bus.
//   Build option: JOYPAD_POLLER_DEBOUNCE_EN - commit a sample only when it
//   matches the previous poll's sample.
//   Ports:
//     clk, rst            - clock, asynchronous active-high reset
//     br_start            - one-cycle start pulse to the bridge
//     br_addr, br_rdata   - bridge readback select / data (combinational)
//     bus_addr, bus_wen,
//     bus_wdata, bus_rdata- CPU register access (read is combinational)
//     irq                 - level interrupt
module joypad_poller #(
    parameter int unsigned POLL_PERIOD = 833_333,
    parameter int unsigned TIMEOUT     = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       br_start,
    output logic [1:0] br_addr,
    input  logic [7:0] br_rdata,
    input  logic [2:0] bus_addr,
    input  logic       bus_wen,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       irq
);

    import joypad_poller_pkg::*;

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    jp_state_t       r_state, w_state_nxt;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_new, r_cur, r_pressed, r_released, r_irq_mask;
    logic            r_auto_en, r_trig_pend, r_have_data, r_timeout_err;

    logic       w_tick, w_timeout, w_enter_check, w_set_timeout;
    logic       w_fetch, w_update, w_commit, w_to_run;
    logic       w_wr_ctrl;
    logic [7:0] w_clr_pressed, w_clr_released;

    poll_timer #(.PERIOD(POLL_PERIOD)) u_poll_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_timeout = (r_to_cnt >= TO_W'(TIMEOUT - 1));
    assign w_to_run  = (r_state == ST_CHECK) || (r_state == ST_LAUNCH) || (r_state == ST_WAIT);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        br_start      = 1'b0;
        br_addr       = BR_ADDR_READY;
        w_set_timeout = 1'b0;
        w_fetch       = 1'b0;
        w_update      = 1'b0;
        case (r_state)
            ST_IDLE:
                if ((w_tick & r_auto_en) | r_trig_pend) w_state_nxt = ST_CHECK;
            ST_CHECK:
                if (br_rdata[0]) begin
                    br_start    = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end
            ST_LAUNCH:
                w_state_nxt = ST_WAIT;
            ST_WAIT:
                if (br_rdata[0]) begin
                    w_state_nxt = ST_VALID;
                end else if (w_timeout) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            ST_VALID: begin
                br_addr     = BR_ADDR_VALID;
                w_state_nxt = br_rdata[0] ? ST_FETCH : ST_IDLE;
            end
            ST_FETCH: begin
                br_addr     = BR_ADDR_JOYPAD;
                w_fetch     = 1'b1;
                w_state_nxt = ST_UPDATE;
            end
            ST_UPDATE: begin
                w_update    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:
                w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter_check = (r_state == ST_IDLE) && (w_state_nxt == ST_CHECK);

    // ---------------- commit qualification ----------------
`ifdef JOYPAD_POLLER_DEBOUNCE_EN
    logic [7:0] r_candidate;

    // Compare against the previous poll's sample, then replace it.
    assign w_commit = w_update && (r_new == r_candidate);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_candidate <= '0;
        else if (w_update) r_candidate <= r_new;
    end
`else
    assign w_commit = w_update;
`endif

    // ---------------- bus write decode ----------------
    assign w_wr_ctrl      = bus_wen && (bus_addr == JP_REG_CTRL);
    assign w_clr_pressed  = (bus_wen && (bus_addr == JP_REG_PRESSED))  ? bus_wdata : '0;
    assign w_clr_released = (bus_wen && (bus_addr == JP_REG_RELEASED)) ? bus_wdata : '0;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_new         <= '0;
            r_cur         <= '0;
            r_pressed     <= '0;
            r_released    <= '0;
            r_irq_mask    <= '0;
            r_auto_en     <= 1'b0;
            r_trig_pend   <= 1'b0;
            r_have_data   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_enter_check)              r_to_cnt <= '0;
            else if (w_to_run && !w_timeout) r_to_cnt <= r_to_cnt + 1'b1;

            if (w_fetch) r_new <= ~br_rdata;

            // Set terms are ORed after the W1C mask so a same-cycle event wins.
            r_pressed  <= (r_pressed  & ~w_clr_pressed)  | (w_commit ? (r_new & ~r_cur) : '0);
            r_released <= (r_released & ~w_clr_released) | (w_commit ? (~r_new & r_cur) : '0);

            if (w_commit) begin
                r_cur       <= r_new;
                r_have_data <= 1'b1;
            end

            if (bus_wen && (bus_addr == JP_REG_IRQ_MASK)) r_irq_mask <= bus_wdata;
            if (w_wr_ctrl) r_auto_en <= bus_wdata[0];

            // A trigger written on the same edge the FSM enters CHECK is kept
            // for the following poll rather than being absorbed.
            if (w_wr_ctrl && bus_wdata[1]) r_trig_pend <= 1'b1;
            else if (w_enter_check)        r_trig_pend <= 1'b0;

            if (w_set_timeout)                  r_timeout_err <= 1'b1;
            else if (w_wr_ctrl && bus_wdata[2]) r_timeout_err <= 1'b0;
        end
    end

    // ---------------- read mux / irq ----------------
    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            JP_REG_STATUS:   bus_rdata = {5'b0, r_timeout_err, (r_state != ST_IDLE), r_have_data};
            JP_REG_BUTTONS:  bus_rdata = r_cur;
            JP_REG_PRESSED:  bus_rdata = r_pressed;
            JP_REG_RELEASED: bus_rdata = r_released;
            JP_REG_IRQ_MASK: bus_rdata = r_irq_mask;
            JP_REG_CTRL:     bus_rdata = {7'b0, r_auto_en};
            default:         bus_rdata = '0;
        endcase
    end

    assign irq = |((r_pressed | r_released) & r_irq_mask);

endmodule
